// File: rtl/gticc_rx_deframer_if.sv
// rtl/gticc_rx_deframer_if.sv - GT RX word input and deframed payload/status bundle
interface gticc_rx_deframer_if;
  logic [31:0] rx_data;
  logic [3:0]  rx_charisk;
  logic        rx_byteisaligned;
  logic        rx_resetdone;
  logic        link_up;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_sof;
  logic        m_eof;
  logic [7:0]  m_tag;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] err_cnt;

  modport master (
    input  rx_data, rx_charisk, rx_byteisaligned, rx_resetdone,
    output link_up, m_valid, m_data, m_sof, m_eof, m_tag, frame_ok, frame_err, err_cnt
  );

  modport slave (
    output rx_data, rx_charisk, rx_byteisaligned, rx_resetdone,
    input  link_up, m_valid, m_data, m_sof, m_eof, m_tag, frame_ok, frame_err, err_cnt
  );
endinterface

// File: rtl/gticc_rx_deframer.sv
// rtl/gticc_rx_deframer.sv - GTX RX deframer: comma lock, length-delimited checksummed frame extraction
module gticc_rx_deframer #(
  parameter int LOCK_COUNT   = 64,
  parameter int UNLOCK_COUNT = 8,
  parameter int MAX_LEN      = 1024
) (
  input  logic                clk,
  input  logic                rst,
  gticc_rx_deframer_if.master bus
);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);
  localparam int RW = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {S_HUNT, S_LOCKED, S_FRAME, S_WAIT_EOF} state_t;
  typedef enum logic [2:0] {W_IDLE, W_SOF, W_EOF, W_DATA, W_BAD} wclass_t;

  state_t        state;
  wclass_t       wclass;
  logic [LW-1:0] lock_cnt;
  logic [UW-1:0] bad_cnt;
  logic [RW-1:0] remaining;
  logic          first_word;
  logic [15:0]   csum;
  logic [15:0]   csum_next;
  logic [15:0]   hdr_field;
  logic          link_ok;
  logic          len_zero;
  logic          len_fits;
  logic          sof_take;
  logic          bad_err;
  logic          unlock;
  logic          frame_err_c;
  logic          frame_ok_c;
  logic          proto_err_c;
  logic          err_inc;

  assign link_ok   = bus.rx_resetdone & bus.rx_byteisaligned;
  assign hdr_field = bus.rx_data[23:8];
  assign len_zero  = (hdr_field == 16'd0);
  assign len_fits  = (hdr_field <= 16'(MAX_LEN));
  assign csum_next = csum + bus.rx_data[15:0] + bus.rx_data[31:16];

  always_comb begin
    wclass = W_BAD;
    if (bus.rx_charisk == 4'b0000) begin
      wclass = W_DATA;
    end else if (bus.rx_charisk == 4'b0001) begin
      case (bus.rx_data[7:0])
        8'hBC:   wclass = W_IDLE;
        8'hFB:   wclass = W_SOF;
        8'hFD:   wclass = W_EOF;
        default: wclass = W_BAD;
      endcase
    end
  end

  // A BAD word always closes an open frame, so no frame can still be open when unlock fires.
  assign bad_err  = link_ok && (state != S_HUNT) && (wclass == W_BAD);
  assign unlock   = bad_err && (bad_cnt == UW'(UNLOCK_COUNT - 1));
  assign sof_take = link_ok && (wclass == W_SOF) && ((state == S_LOCKED) || (state == S_FRAME));

  always_comb begin
    frame_err_c = 1'b0;
    frame_ok_c  = 1'b0;
    proto_err_c = 1'b0;
    if (!link_ok) begin
      frame_err_c = (state == S_FRAME) || (state == S_WAIT_EOF);
    end else begin
      case (state)
        S_LOCKED: begin
          case (wclass)
            W_SOF:          proto_err_c = !len_fits;
            W_DATA, W_EOF:  proto_err_c = 1'b1;
            default:        proto_err_c = 1'b0;
          endcase
        end
        S_FRAME: begin
          if (wclass != W_DATA) begin
            frame_err_c = 1'b1;
            proto_err_c = (wclass == W_SOF) && !len_fits;
          end
        end
        S_WAIT_EOF: begin
          if (wclass == W_EOF) begin
            frame_ok_c  = (hdr_field == csum);
            frame_err_c = (hdr_field != csum);
          end else if (wclass != W_IDLE) begin
            frame_err_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err_inc = bad_err | frame_err_c | proto_err_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_HUNT;
      lock_cnt      <= '0;
      bad_cnt       <= '0;
      remaining     <= '0;
      first_word    <= 1'b0;
      csum          <= '0;
      bus.link_up   <= 1'b0;
      bus.m_valid   <= 1'b0;
      bus.m_data    <= '0;
      bus.m_sof     <= 1'b0;
      bus.m_eof     <= 1'b0;
      bus.m_tag     <= '0;
      bus.frame_ok  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.err_cnt   <= '0;
    end else begin
      bus.m_valid   <= 1'b0;
      bus.m_sof     <= 1'b0;
      bus.m_eof     <= 1'b0;
      bus.frame_ok  <= frame_ok_c;
      bus.frame_err <= frame_err_c;
      if (err_inc && (bus.err_cnt != 16'hFFFF)) begin
        bus.err_cnt <= bus.err_cnt + 16'd1;
      end

      if (!link_ok) begin
        state       <= S_HUNT;
        bus.link_up <= 1'b0;
        lock_cnt    <= '0;
        bad_cnt     <= '0;
      end else if (state == S_HUNT) begin
        if (wclass != W_IDLE) begin
          lock_cnt <= '0;
        end else if (lock_cnt == LW'(LOCK_COUNT - 1)) begin
          state       <= S_LOCKED;
          bus.link_up <= 1'b1;
          lock_cnt    <= '0;
        end else begin
          lock_cnt <= lock_cnt + LW'(1);
        end
      end else if (unlock) begin
        state       <= S_HUNT;
        bus.link_up <= 1'b0;
        bad_cnt     <= '0;
      end else begin
        bad_cnt <= (wclass == W_BAD) ? bad_cnt + UW'(1) : '0;
        case (state)
          S_FRAME: begin
            if (wclass == W_DATA) begin
              bus.m_valid <= 1'b1;
              bus.m_data  <= bus.rx_data;
              bus.m_sof   <= first_word;
              bus.m_eof   <= (remaining == RW'(1));
              csum        <= csum_next;
              remaining   <= remaining - RW'(1);
              first_word  <= 1'b0;
              if (remaining == RW'(1)) begin
                state <= S_WAIT_EOF;
              end
            end else begin
              state <= S_LOCKED;
            end
          end
          S_WAIT_EOF: begin
            if (wclass != W_IDLE) begin
              state <= S_LOCKED;
            end
          end
          default: ;
        endcase
        // An SOF that aborts a running frame opens the next one in the same cycle.
        if (sof_take && len_fits) begin
          csum       <= '0;
          first_word <= 1'b1;
          remaining  <= hdr_field[RW-1:0];
          bus.m_tag  <= bus.rx_data[31:24];
          state      <= len_zero ? S_WAIT_EOF : S_FRAME;
        end
      end
    end
  end
endmodule

// File: tb/tb_gticc_rx_deframer.sv
// tb/tb_gticc_rx_deframer.sv - scoreboard bench for gticc_rx_deframer with a word-level reference model
module tb_gticc_rx_deframer;
  localparam int LOCK_COUNT   = 64;
  localparam int UNLOCK_COUNT = 8;
  localparam int MAX_LEN      = 1024;
  localparam logic [31:0] IDLE_W = 32'h0000_00BC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gticc_rx_deframer_if bus();

  gticc_rx_deframer #(
    .LOCK_COUNT(LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT),
    .MAX_LEN(MAX_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {int stamp; logic [31:0] data; logic sof; logic eof; logic [7:0] tag;} pay_t;
  typedef struct {int stamp; logic ok; logic err;} res_t;
  typedef struct {int stamp; logic up; logic [15:0] errs; logic [31:0] data; logic [7:0] tag;} stat_t;

  pay_t  q_pay[$];
  res_t  q_res[$];
  stat_t q_stat[$];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: link and frame progress tracked as counts and flags.
  bit          md_up, md_in_frame, md_want_eof;
  int          md_idle_run, md_bad_run, md_left, md_seen;
  logic [15:0] md_sum, md_errs;
  logic [7:0]  md_tag;
  logic [31:0] md_last;

  function automatic logic [31:0] sof_w(input logic [15:0] len, input logic [7:0] tag);
    return {tag, len, 8'hFB};
  endfunction

  function automatic logic [31:0] eof_w(input logic [15:0] cs);
    return {8'h00, cs, 8'hFD};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic open_frame(input logic [31:0] d, output bit pe);
    int len;
    len = int'(d[23:8]);
    pe = 1'b0;
    if (len > MAX_LEN) begin
      pe = 1'b1;
    end else begin
      md_tag  = d[31:24];
      md_sum  = 16'd0;
      md_seen = 0;
      if (len == 0) md_want_eof = 1'b1;
      else begin
        md_in_frame = 1'b1;
        md_left     = len;
      end
    end
  endtask

  task automatic model_step(input logic r, input logic [31:0] d, input logic [3:0] k, input logic link_ok);
    int stamp;
    bit is_idle, is_sof, is_eof, is_data, is_bad, ferr, perr, fok, cnt_bad;
    pay_t p; res_t rs; stat_t s;
    stamp   = cyc + 1;
    is_data = (k == 4'b0000);
    is_idle = (k == 4'b0001) && (d[7:0] == 8'hBC);
    is_sof  = (k == 4'b0001) && (d[7:0] == 8'hFB);
    is_eof  = (k == 4'b0001) && (d[7:0] == 8'hFD);
    is_bad  = !(is_data || is_idle || is_sof || is_eof);
    ferr = 0; perr = 0; fok = 0; cnt_bad = 0;
    if (r) begin
      md_up = 0; md_in_frame = 0; md_want_eof = 0;
      md_idle_run = 0; md_bad_run = 0; md_left = 0; md_seen = 0;
      md_sum = 0; md_errs = 0; md_tag = 0; md_last = 0;
    end else if (!link_ok) begin
      ferr = md_in_frame || md_want_eof;
      md_up = 0; md_in_frame = 0; md_want_eof = 0; md_idle_run = 0; md_bad_run = 0;
    end else if (!md_up) begin
      md_idle_run = is_idle ? md_idle_run + 1 : 0;
      if (md_idle_run == LOCK_COUNT) begin
        md_up = 1; md_idle_run = 0; md_bad_run = 0;
      end
    end else begin
      cnt_bad = is_bad;
      md_bad_run = is_bad ? md_bad_run + 1 : 0;
      if (md_in_frame) begin
        if (is_data) begin
          p.stamp = stamp; p.data = d; p.sof = (md_seen == 0); p.eof = (md_left == 1); p.tag = md_tag;
          q_pay.push_back(p);
          md_sum  = md_sum + d[15:0] + d[31:16];
          md_last = d;
          md_seen++;
          md_left--;
          if (md_left == 0) begin
            md_in_frame = 0; md_want_eof = 1;
          end
        end else begin
          ferr = 1; md_in_frame = 0;
          if (is_sof) open_frame(d, perr);
        end
      end else if (md_want_eof) begin
        if (is_eof) begin
          if (d[23:8] == md_sum) fok = 1; else ferr = 1;
          md_want_eof = 0;
        end else if (!is_idle) begin
          ferr = 1; md_want_eof = 0;
        end
      end else if (is_sof) begin
        open_frame(d, perr);
      end else if (is_data || is_eof) begin
        perr = 1;
      end
      if (md_bad_run == UNLOCK_COUNT) begin
        if (md_in_frame || md_want_eof) ferr = 1;
        md_up = 0; md_idle_run = 0; md_bad_run = 0; md_in_frame = 0; md_want_eof = 0;
      end
    end
    if ((ferr || perr || cnt_bad) && (md_errs != 16'hFFFF)) md_errs = md_errs + 16'd1;
    if (fok || ferr) begin
      rs.stamp = stamp; rs.ok = fok; rs.err = ferr;
      q_res.push_back(rs);
    end
    s.stamp = stamp; s.up = md_up; s.errs = md_errs; s.data = md_last; s.tag = md_tag;
    q_stat.push_back(s);
  endtask

  task automatic step(input logic r, input logic [31:0] d, input logic [3:0] k, input logic ba, input logic rd);
    @(posedge clk);
    #1;
    rst = r;
    bus.rx_data = d;
    bus.rx_charisk = k;
    bus.rx_byteisaligned = ba;
    bus.rx_resetdone = rd;
    model_step(r, d, k, ba & rd);
  endtask

  task automatic w(input logic [31:0] d, input logic [3:0] k);
    step(1'b0, d, k, 1'b1, 1'b1);
  endtask

  task automatic idles(input int n);
    repeat (n) w(IDLE_W, 4'b0001);
  endtask

  task automatic rand_frame();
    int len, mode, cut;
    logic [7:0] tag;
    logic [15:0] s;
    logic [31:0] d;
    mode = $urandom_range(0, 9);
    len  = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 12);
    cut  = (len > 0) ? $urandom_range(0, len - 1) : 0;
    tag  = 8'($urandom);
    s    = 16'd0;
    w(sof_w(16'(len), tag), 4'b0001);
    for (int i = 0; i < len; i++) begin
      if (mode == 0 && i == cut) begin
        case ($urandom_range(0, 3))
          0: w(IDLE_W, 4'b0001);
          1: w(eof_w(s), 4'b0001);
          2: w(sof_w(16'd2000, tag), 4'b0001);
          default: w($urandom, 4'b1111);
        endcase
        idles($urandom_range(1, 3));
        return;
      end
      d = $urandom;
      s = s + d[15:0] + d[31:16];
      w(d, 4'b0000);
    end
    idles($urandom_range(0, 2));
    w(eof_w((mode == 1) ? (s ^ 16'h0001) : s), 4'b0001);
    idles($urandom_range(0, 3));
  endtask

  always @(negedge clk) begin : monitor
    stat_t s;
    pay_t  p;
    res_t  r;
    logic  ev;
    if (q_stat.size() > 0) begin
      if (q_stat[0].stamp == cyc) begin
        s = q_stat.pop_front();
        chk("link_up", 32'(bus.link_up), 32'(s.up));
        chk("err_cnt", 32'(bus.err_cnt), 32'(s.errs));
        chk("m_data_held", bus.m_data, s.data);
        chk("m_tag_held", 32'(bus.m_tag), 32'(s.tag));
      end
    end
    ev = 1'b0;
    if (q_pay.size() > 0) ev = (q_pay[0].stamp == cyc);
    if (ev || bus.m_valid === 1'b1) begin
      chk("m_valid", 32'(bus.m_valid), 32'(ev));
      if (ev) begin
        p = q_pay.pop_front();
        if (bus.m_valid === 1'b1) begin
          chk("m_data", bus.m_data, p.data);
          chk("m_sof", 32'(bus.m_sof), 32'(p.sof));
          chk("m_eof", 32'(bus.m_eof), 32'(p.eof));
          chk("m_tag", 32'(bus.m_tag), 32'(p.tag));
        end
      end
    end
    ev = 1'b0;
    if (q_res.size() > 0) ev = (q_res[0].stamp == cyc);
    if (ev || bus.frame_ok === 1'b1 || bus.frame_err === 1'b1) begin
      if (ev) begin
        r = q_res.pop_front();
        chk("frame_ok", 32'(bus.frame_ok), 32'(r.ok));
        chk("frame_err", 32'(bus.frame_err), 32'(r.err));
      end else begin
        chk("frame_pulse_spurious", 32'({bus.frame_ok, bus.frame_err}), 32'(0));
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [15:0] s;
    bus.rx_data = IDLE_W;
    bus.rx_charisk = 4'b0001;
    bus.rx_byteisaligned = 1'b1;
    bus.rx_resetdone = 1'b1;
    repeat (3) step(1'b1, IDLE_W, 4'b0001, 1'b1, 1'b1);

    // lock acquisition: an interrupted run of 63 does not lock
    idles(LOCK_COUNT - 1);
    w(32'h1234_5678, 4'b0000);
    idles(LOCK_COUNT);

    // good frame, checksum mismatch, zero-length, short abort
    for (int pass = 0; pass < 2; pass++) begin
      w(sof_w(16'd3, 8'hA5), 4'b0001);
      w(32'h0001_0002, 4'b0000);
      w(32'h0003_0004, 4'b0000);
      w(32'h0005_0006, 4'b0000);
      w(eof_w((pass == 0) ? 16'h0015 : 16'h0014), 4'b0001);
      idles(2);
    end
    w(sof_w(16'd0, 8'h3C), 4'b0001);
    w(eof_w(16'h0000), 4'b0001);
    idles(2);
    w(sof_w(16'd4, 8'h77), 4'b0001);
    w(32'hDEAD_BEEF, 4'b0000);
    w(32'hCAFE_F00D, 4'b0000);
    idles(3);
    w(sof_w(16'd1, 8'h42), 4'b0001);
    w(32'h0102_0304, 4'b0000);
    w(eof_w(16'h0406), 4'b0001);
    idles(2);

    repeat (40) rand_frame();

    // sustained corruption mid-frame drops the link
    w(sof_w(16'd4, 8'h19), 4'b0001);
    w(32'h1111_2222, 4'b0000);
    repeat (UNLOCK_COUNT) w($urandom, 4'b1111);
    idles(LOCK_COUNT);

    // one-cycle alignment loss while locked, then relock
    idles(3);
    step(1'b0, IDLE_W, 4'b0001, 1'b0, 1'b1);
    idles(LOCK_COUNT);

    // random line noise with occasional link drops
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1:    w(IDLE_W, 4'b0001);
        2, 3, 4: w($urandom, 4'b0000);
        5:       w(sof_w(($urandom_range(0, 4) == 0) ? 16'd1025 : 16'($urandom_range(0, 3)), 8'($urandom)), 4'b0001);
        6:       w(eof_w(16'($urandom_range(0, 3))), 4'b0001);
        7:       w($urandom, 4'($urandom_range(2, 15)));
        8:       w($urandom, 4'b0001);
        default: step(1'b0, IDLE_W, 4'b0001, 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 5) != 0));
      endcase
    end
    idles(LOCK_COUNT + 2);

    // largest legal frame and the first oversize length
    s = 16'd0;
    w(sof_w(16'(MAX_LEN), 8'hE1), 4'b0001);
    for (int i = 0; i < MAX_LEN; i++) begin
      d = $urandom;
      s = s + d[15:0] + d[31:16];
      w(d, 4'b0000);
    end
    w(eof_w(s), 4'b0001);
    w(sof_w(16'(MAX_LEN + 1), 8'hE2), 4'b0001);
    w(32'hAAAA_5555, 4'b0000);
    idles(2);

    // reset mid-frame is silent
    w(sof_w(16'd4, 8'h5A), 4'b0001);
    w(32'h0F0F_F0F0, 4'b0000);
    step(1'b1, IDLE_W, 4'b0001, 1'b1, 1'b1);
    idles(LOCK_COUNT + 1);

    // error counter saturation
    repeat (65540) w(sof_w(16'd1025, 8'h11), 4'b0001);
    repeat (UNLOCK_COUNT - 1) w($urandom, 4'b1111);
    w(sof_w(16'd2, 8'h66), 4'b0001);
    w(32'h0000_0001, 4'b0000);
    w(IDLE_W, 4'b0001);
    idles(2);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("payload_drained", 32'(q_pay.size()), 32'(0));
    chk("results_drained", 32'(q_res.size()), 32'(0));
    chk("status_drained", 32'(q_stat.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
